// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-cycle en/flush of every pipeline latch by fixed priority.
// Enables are combinational off current inputs; halt, wdog_err and stall_cnt are registered.
module hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             ex_ren,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic             wdog_err,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        RUN,
        DSTALL,
        HALT_DRAIN,
        HALTED
    } state_t;

    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] WDOG_MAX = CW'(WDOG_CYCLES);

    state_t          state_q, state_d;
    logic [CW-1:0]   wdog_cnt_q, wdog_cnt_d;
    logic            wdog_err_q, wdog_err_d;
    logic            halt_q, halt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic dreq, dwait, lu, active;

    assign dreq   = mem_ren | mem_wen;
    assign dwait  = dreq & ~dhit;
    assign lu     = ex_ren && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign active = (state_q == RUN) || (state_q == DSTALL);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        state_d     = state_q;

        case (state_q)
            RUN, DSTALL: begin
                state_d = RUN;
                if (dwait) begin
                    memwb_flush = 1'b1;
                    state_d     = DSTALL;
                end else if (mem_redirect) begin
                    pc_en       = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                end else if (mem_halt) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_en    = 1'b1;
                    state_d     = HALT_DRAIN;
                end else if (lu) begin
                    idex_flush  = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                end else if (!ihit) begin
                    ifid_flush  = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                end
            end
            HALT_DRAIN: begin
                memwb_en = 1'b1;
                state_d  = HALTED;
            end
            default: state_d = HALTED;
        endcase

        // Reset forces every latch idle regardless of the decode above.
        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_flush  = 1'b0;
            exmem_en    = 1'b0;
            exmem_flush = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b0;
        end
    end

    always_comb begin
        wdog_err_d  = wdog_err_q;
        wdog_cnt_d  = '0;
        if (active && dwait) begin
            wdog_cnt_d = (wdog_cnt_q == WDOG_MAX) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
            if (wdog_cnt_d == WDOG_MAX) wdog_err_d = 1'b1;
        end
        halt_d      = halt_q | (state_d == HALTED);
        stall_cnt_d = stall_cnt_q + 32'((active && !pc_en) ? 1 : 0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            wdog_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_err_q  <= wdog_err_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halt      = halt_q;
    assign wdog_err  = wdog_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed stimulus for hazard_ctrl, checked each cycle against a rule-level model.
module tb_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int WDOG  = 4;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, mem_ren, mem_wen, mem_redirect, mem_halt, ex_ren, id_uses_rt;
    logic [REG_W-1:0] ex_rd, id_rs, id_rt;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
    logic memwb_en, memwb_flush, halt, wdog_err;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // model state: mode 0 = running, 1 = draining halt, 2 = halted
    int          m_mode = 0;
    int          m_dcnt = 0;
    bit          m_err  = 1'b0;
    int unsigned m_scnt = 0;

    hazard_ctrl #(.REG_W(REG_W), .WDOG_CYCLES(WDOG)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt), .ex_ren(ex_ren), .ex_rd(ex_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halt(halt), .wdog_err(wdog_err),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_redirect = 1'b0;
        mem_halt = 1'b0; ex_ren = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit pe, fe, ff, de, df, xe, xf, we, wf, dw, lu;
        {pe, fe, ff, de, df, xe, xf, we, wf} = '0;
        @(negedge CLK);
        dw = (mem_ren || mem_wen) && !dhit;
        lu = ex_ren && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        if (!RST) begin
            if (m_mode == 0) begin
                if (dw)                 wf = 1;
                else if (mem_redirect)  begin pe = 1; ff = 1; df = 1; xf = 1; we = 1; end
                else if (mem_halt)      begin ff = 1; df = 1; xf = 1; we = 1; end
                else if (lu)            begin df = 1; xe = 1; we = 1; end
                else if (!ihit)         begin ff = 1; de = 1; xe = 1; we = 1; end
                else                    begin pe = 1; fe = 1; de = 1; xe = 1; we = 1; end
            end else if (m_mode == 1) begin
                we = 1;
            end
        end
        check("ctl", {23'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                      exmem_flush, memwb_en, memwb_flush},
                     {23'd0, pe, fe, ff, de, df, xe, xf, we, wf});
        check("halt", {31'd0, halt}, {31'd0, m_mode == 2});
        check("wdog_err", {31'd0, wdog_err}, {31'd0, m_err});
        check("stall_cnt", stall_cnt, m_scnt);

        if (RST) begin
            m_mode = 0; m_dcnt = 0; m_err = 1'b0; m_scnt = 0;
        end else if (m_mode == 0) begin
            if (dw) begin
                if (m_dcnt < WDOG) m_dcnt++;
                if (m_dcnt >= WDOG) m_err = 1'b1;
            end else begin
                m_dcnt = 0;
                if (!mem_redirect && mem_halt) m_mode = 1;
            end
            if (!pe) m_scnt++;
        end else begin
            m_mode = 2;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        for (int i = 0; i < n; i++) step();
        RST = 1'b0;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        #1;

        // reset with ihit high, then plain running
        do_reset(2);
        step();
        check("t1_stall_zero", stall_cnt, 32'd0);

        // load-use on rs, then ex_rd == 0 suppresses it
        ex_ren = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        step();
        ex_rd = 5'd0; id_rs = 5'd0;
        step();
        check("t2_stall_one", stall_cnt, 32'd1);
        idle_inputs();

        // dmem wait holding a redirect, then dhit releases it
        do_reset(1);
        mem_ren = 1'b1; mem_redirect = 1'b1; dhit = 1'b0;
        repeat (3) step();
        check("t3_stall_three", stall_cnt, 32'd3);
        dhit = 1'b1;
        step();
        idle_inputs();
        step();

        // watchdog: four waiting cycles trip it, dhit does not clear it
        do_reset(1);
        mem_wen = 1'b1; dhit = 1'b0;
        repeat (3) step();
        check("t4_wdog_not_yet", {31'd0, wdog_err}, 32'd0);
        step();
        check("t4_wdog_set", {31'd0, wdog_err}, 32'd1);
        dhit = 1'b1;
        repeat (2) step();
        check("t4_wdog_sticky", {31'd0, wdog_err}, 32'd1);
        idle_inputs();

        // halt then ignored activity
        do_reset(1);
        mem_halt = 1'b1;
        step();
        mem_halt = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            ihit = i[0]; dhit = ~i[0]; mem_ren = 1'b1; mem_redirect = i[1];
            step();
        end
        check("t5_halted", {31'd0, halt}, 32'd1);
        idle_inputs();

        // imem miss together with load-use on rt
        do_reset(1);
        ihit = 1'b0; ex_ren = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd2;
        step();
        idle_inputs();
        step();

        // random episodes, each beginning with a reset (sometimes mid-stall or mid-halt)
        for (int ep = 0; ep < 60; ep++) begin
            do_reset(1 + $urandom_range(0, 1));
            for (int c = 0; c < $urandom_range(20, 60); c++) begin
                ihit         = ($urandom_range(0, 99) < 80);
                dhit         = ($urandom_range(0, 99) < 45);
                mem_ren      = ($urandom_range(0, 99) < 35);
                mem_wen      = ($urandom_range(0, 99) < 15);
                mem_redirect = ($urandom_range(0, 99) < 15);
                mem_halt     = ($urandom_range(0, 99) < 3);
                ex_ren       = ($urandom_range(0, 99) < 40);
                ex_rd        = REG_W'($urandom_range(0, 3));
                id_rs        = REG_W'($urandom_range(0, 3));
                id_rt        = REG_W'($urandom_range(0, 3));
                id_uses_rt   = $urandom_range(0, 1) == 1;
                step();
            end
            idle_inputs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
